// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the 5-stage pipeline datapath and its hazard controller.
// master = pipeline side, slave = controller side; dbg_state is 1 while a multiply holds EX.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] rs_ID;
    logic [REG_AW-1:0] rt_ID;
    logic              UsesRt_ID;
    logic              JR_ID;
    logic [REG_AW-1:0] rs_EX;
    logic [REG_AW-1:0] rt_EX;
    logic              MemRead_EX;
    logic              RegWrite_EX;
    logic [REG_AW-1:0] WriteReg_EX;
    logic              MulStart_EX;
    logic              MemRead_MEM;
    logic              RegWrite_MEM;
    logic [REG_AW-1:0] WriteReg_MEM;
    logic              RegWrite_WB;
    logic [REG_AW-1:0] WriteReg_WB;
    logic              PCSrc_MEM;
    logic              PCWrite;
    logic              IFID_Write;
    logic              IFID_Flush;
    logic              IDEX_Write;
    logic              IDEX_Flush;
    logic              EXMEM_Flush;
    logic [1:0]        FwdA_EX;
    logic [1:0]        FwdB_EX;
    logic [1:0]        FwdJR_ID;
    logic [CNT_W-1:0]  StallCnt;
    logic [CNT_W-1:0]  FlushCnt;
    logic              dbg_state;

    modport master (
        output rs_ID, rt_ID, UsesRt_ID, JR_ID, rs_EX, rt_EX, MemRead_EX, RegWrite_EX,
               WriteReg_EX, MulStart_EX, MemRead_MEM, RegWrite_MEM, WriteReg_MEM,
               RegWrite_WB, WriteReg_WB, PCSrc_MEM,
        input  PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Flush,
               FwdA_EX, FwdB_EX, FwdJR_ID, StallCnt, FlushCnt, dbg_state
    );

    modport slave (
        input  rs_ID, rt_ID, UsesRt_ID, JR_ID, rs_EX, rt_EX, MemRead_EX, RegWrite_EX,
               WriteReg_EX, MulStart_EX, MemRead_MEM, RegWrite_MEM, WriteReg_MEM,
               RegWrite_WB, WriteReg_WB, PCSrc_MEM,
        output PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Flush,
               FwdA_EX, FwdB_EX, FwdJR_ID, StallCnt, FlushCnt, dbg_state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding selects, load-use/JR stalls,
// multi-cycle multiply hold and MEM branch flush. Define HAZARD_STATS_EN for stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic                Clk,
    input  logic                Rst,
    pipe_hazard_ctrl_if.slave   bus
);
    localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

    typedef enum logic {ST_RUN = 1'b0, ST_MUL = 1'b1} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_mul_cnt, w_mul_cnt_nxt;
    logic            w_lu_stall, w_jr_stall, w_stall;
    logic [1:0]      w_fwd_a, w_fwd_b, w_fwd_jr;

    // Register 0 is hardwired to zero, so it never produces a dependency.
    function automatic logic f_match(input logic rw, input logic [REG_AW-1:0] dst,
                                     input logic [REG_AW-1:0] src);
        return rw && (dst != '0) && (dst == src);
    endfunction

    always_comb begin
        w_fwd_a = 2'b00;
        if (f_match(bus.RegWrite_MEM, bus.WriteReg_MEM, bus.rs_EX))     w_fwd_a = 2'b10;
        else if (f_match(bus.RegWrite_WB, bus.WriteReg_WB, bus.rs_EX))  w_fwd_a = 2'b01;
        w_fwd_b = 2'b00;
        if (f_match(bus.RegWrite_MEM, bus.WriteReg_MEM, bus.rt_EX))     w_fwd_b = 2'b10;
        else if (f_match(bus.RegWrite_WB, bus.WriteReg_WB, bus.rt_EX))  w_fwd_b = 2'b01;
        w_fwd_jr = 2'b00;
        if (bus.JR_ID) begin
            if (f_match(bus.RegWrite_MEM, bus.WriteReg_MEM, bus.rs_ID) && !bus.MemRead_MEM)
                w_fwd_jr = 2'b01;
            else if (f_match(bus.RegWrite_WB, bus.WriteReg_WB, bus.rs_ID))
                w_fwd_jr = 2'b10;
        end
    end

    // A loaded value in MEM is not yet available to the ID-stage jr comparator path.
    assign w_jr_stall = bus.JR_ID &&
                        (f_match(bus.RegWrite_EX, bus.WriteReg_EX, bus.rs_ID) ||
                         (bus.MemRead_MEM && f_match(bus.RegWrite_MEM, bus.WriteReg_MEM, bus.rs_ID)));
    assign w_lu_stall = bus.MemRead_EX &&
                        (f_match(bus.RegWrite_EX, bus.WriteReg_EX, bus.rs_ID) ||
                         (bus.UsesRt_ID && f_match(bus.RegWrite_EX, bus.WriteReg_EX, bus.rt_ID)));
    assign w_stall = w_lu_stall || w_jr_stall;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state   <= ST_RUN;
            r_mul_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mul_cnt <= w_mul_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mul_cnt_nxt   = r_mul_cnt;
        bus.PCWrite     = 1'b1;
        bus.IFID_Write  = 1'b1;
        bus.IDEX_Write  = 1'b1;
        bus.IFID_Flush  = 1'b0;
        bus.IDEX_Flush  = 1'b0;
        bus.EXMEM_Flush = 1'b0;
        bus.FwdA_EX     = w_fwd_a;
        bus.FwdB_EX     = w_fwd_b;
        bus.FwdJR_ID    = w_fwd_jr;
        case (r_state)
            ST_RUN: begin
                if (w_stall) begin
                    bus.PCWrite    = 1'b0;
                    bus.IFID_Write = 1'b0;
                    bus.IDEX_Flush = 1'b1;
                end
                if (bus.MulStart_EX && (MUL_LAT > 1)) begin
                    w_state_nxt   = ST_MUL;
                    w_mul_cnt_nxt = CW'(MUL_LAT - 1);
                end
            end
            ST_MUL: begin
                bus.PCWrite     = 1'b0;
                bus.IFID_Write  = 1'b0;
                bus.IDEX_Write  = 1'b0;
                bus.EXMEM_Flush = 1'b1;
                if (r_mul_cnt <= CW'(1)) begin
                    w_state_nxt   = ST_RUN;
                    w_mul_cnt_nxt = '0;
                end else begin
                    w_mul_cnt_nxt = r_mul_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt   = ST_RUN;
                w_mul_cnt_nxt = '0;
            end
        endcase
        // A taken branch squashes everything younger, including a multiply in EX.
        if (bus.PCSrc_MEM) begin
            bus.PCWrite     = 1'b1;
            bus.IFID_Write  = 1'b1;
            bus.IDEX_Write  = 1'b1;
            bus.IFID_Flush  = 1'b1;
            bus.IDEX_Flush  = 1'b1;
            bus.EXMEM_Flush = 1'b1;
            w_state_nxt     = ST_RUN;
            w_mul_cnt_nxt   = '0;
        end
        if (!Rst) begin
            bus.PCWrite     = 1'b0;
            bus.IFID_Write  = 1'b0;
            bus.IDEX_Write  = 1'b0;
            bus.IFID_Flush  = 1'b1;
            bus.IDEX_Flush  = 1'b1;
            bus.EXMEM_Flush = 1'b1;
            bus.FwdA_EX     = 2'b00;
            bus.FwdB_EX     = 2'b00;
            bus.FwdJR_ID    = 2'b00;
        end
    end

    assign bus.dbg_state = (r_state == ST_MUL);

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!bus.PCWrite && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (bus.PCSrc_MEM && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign bus.StallCnt = r_stall_cnt;
    assign bus.FlushCnt = r_flush_cnt;
`else
    assign bus.StallCnt = '0;
    assign bus.FlushCnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed test-plan steps followed by random cycles, every
// output checked each cycle against a rule-level model of the hazard behaviour.
module tb_pipe_hazard_ctrl;
    localparam int MUL_LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) bus ();

    pipe_hazard_ctrl #(.REG_AW(5), .MUL_LAT(MUL_LAT), .CNT_W(32)) dut (
        .Clk (clk),
        .Rst (rst_n),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // model: remaining multiply hold cycles and event tallies
    int hold_left = 0;
    int m_stall = 0;
    int m_flush = 0;
    logic e_pcw, e_ifw, e_iff, e_idw, e_idf, e_emf;
    logic [1:0] e_fa, e_fb, e_fj;

    function automatic bit dep(input logic rw, input logic [4:0] d, input logic [4:0] s);
        return (rw == 1'b1) && (d != 5'd0) && (d == s);
    endfunction

    task automatic compute_exp();
        bit stall;
        e_fa = 2'b00;
        if (dep(bus.RegWrite_MEM, bus.WriteReg_MEM, bus.rs_EX)) e_fa = 2'b10;
        else if (dep(bus.RegWrite_WB, bus.WriteReg_WB, bus.rs_EX)) e_fa = 2'b01;
        e_fb = 2'b00;
        if (dep(bus.RegWrite_MEM, bus.WriteReg_MEM, bus.rt_EX)) e_fb = 2'b10;
        else if (dep(bus.RegWrite_WB, bus.WriteReg_WB, bus.rt_EX)) e_fb = 2'b01;
        e_fj = 2'b00;
        if (bus.JR_ID) begin
            if (dep(bus.RegWrite_MEM, bus.WriteReg_MEM, bus.rs_ID) && !bus.MemRead_MEM) e_fj = 2'b01;
            else if (dep(bus.RegWrite_WB, bus.WriteReg_WB, bus.rs_ID)) e_fj = 2'b10;
        end
        stall = (bus.JR_ID && (dep(bus.RegWrite_EX, bus.WriteReg_EX, bus.rs_ID) ||
                 (bus.MemRead_MEM && dep(bus.RegWrite_MEM, bus.WriteReg_MEM, bus.rs_ID)))) ||
                (bus.MemRead_EX && (dep(bus.RegWrite_EX, bus.WriteReg_EX, bus.rs_ID) ||
                 (bus.UsesRt_ID && dep(bus.RegWrite_EX, bus.WriteReg_EX, bus.rt_ID))));
        {e_pcw, e_ifw, e_idw, e_iff, e_idf, e_emf} = 6'b111_000;
        if (!rst_n) begin
            {e_pcw, e_ifw, e_idw, e_iff, e_idf, e_emf} = 6'b000_111;
            e_fa = 2'b00; e_fb = 2'b00; e_fj = 2'b00;
        end else if (bus.PCSrc_MEM) begin
            {e_pcw, e_ifw, e_idw, e_iff, e_idf, e_emf} = 6'b111_111;
        end else if (hold_left > 0) begin
            {e_pcw, e_ifw, e_idw, e_iff, e_idf, e_emf} = 6'b000_001;
        end else if (stall) begin
            {e_pcw, e_ifw, e_idw, e_iff, e_idf, e_emf} = 6'b001_010;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic check_all();
        logic [31:0] e_sc, e_fc;
        compute_exp();
`ifdef HAZARD_STATS_EN
        e_sc = m_stall; e_fc = m_flush;
`else
        e_sc = 0; e_fc = 0;
`endif
        check("PCWrite", 32'(bus.PCWrite), 32'(e_pcw));
        check("IFID_Write", 32'(bus.IFID_Write), 32'(e_ifw));
        check("IFID_Flush", 32'(bus.IFID_Flush), 32'(e_iff));
        check("IDEX_Write", 32'(bus.IDEX_Write), 32'(e_idw));
        check("IDEX_Flush", 32'(bus.IDEX_Flush), 32'(e_idf));
        check("EXMEM_Flush", 32'(bus.EXMEM_Flush), 32'(e_emf));
        check("FwdA_EX", 32'(bus.FwdA_EX), 32'(e_fa));
        check("FwdB_EX", 32'(bus.FwdB_EX), 32'(e_fb));
        check("FwdJR_ID", 32'(bus.FwdJR_ID), 32'(e_fj));
        check("StallCnt", bus.StallCnt, e_sc);
        check("FlushCnt", bus.FlushCnt, e_fc);
        check("in_mul", 32'(bus.dbg_state), 32'(hold_left > 0));
    endtask

    // sample on the falling edge, then advance the model with the values the DUT clocked
    task automatic sample();
        @(negedge clk);
        check_all();
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst_n) begin
            hold_left = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!e_pcw) m_stall++;
            if (bus.PCSrc_MEM) m_flush++;
            if (bus.PCSrc_MEM) hold_left = 0;
            else if (hold_left > 0) hold_left--;
            else if (bus.MulStart_EX && MUL_LAT > 1) hold_left = MUL_LAT - 1;
        end
        #1;
    endtask

    task automatic clear_in();
        bus.rs_ID = 0; bus.rt_ID = 0; bus.UsesRt_ID = 0; bus.JR_ID = 0;
        bus.rs_EX = 0; bus.rt_EX = 0; bus.MemRead_EX = 0; bus.RegWrite_EX = 0;
        bus.WriteReg_EX = 0; bus.MulStart_EX = 0; bus.MemRead_MEM = 0;
        bus.RegWrite_MEM = 0; bus.WriteReg_MEM = 0; bus.RegWrite_WB = 0;
        bus.WriteReg_WB = 0; bus.PCSrc_MEM = 0;
    endtask

    initial begin
        clear_in();
        #3;
        check_all();
        check("rst_pcw", 32'(bus.PCWrite), 32'd0);
        advance();
        sample();
        advance();
        rst_n = 1'b1;

        // load-use: lw $t0 in EX, consumer of $t0 in ID
        clear_in();
        bus.MemRead_EX = 1; bus.RegWrite_EX = 1; bus.WriteReg_EX = 8; bus.rs_ID = 8;
        sample();
        check("lu_pcw", 32'(bus.PCWrite), 32'd0);
        check("lu_idf", 32'(bus.IDEX_Flush), 32'd1);
        advance();
        clear_in();
        bus.MemRead_MEM = 1; bus.RegWrite_MEM = 1; bus.WriteReg_MEM = 8; bus.rs_ID = 8;
        sample();
        check("lu_once", 32'(bus.PCWrite), 32'd1);
        advance();
        clear_in();
        bus.RegWrite_WB = 1; bus.WriteReg_WB = 8; bus.rs_EX = 8;
        sample();
        check("lu_fwd", 32'(bus.FwdA_EX), 32'd1);
        advance();

        // MEM beats WB; register 0 never forwards
        clear_in();
        bus.RegWrite_MEM = 1; bus.WriteReg_MEM = 9; bus.RegWrite_WB = 1; bus.WriteReg_WB = 9;
        bus.rs_EX = 9; bus.rt_EX = 9;
        sample();
        check("fwd_a_mem", 32'(bus.FwdA_EX), 32'd2);
        check("fwd_b_mem", 32'(bus.FwdB_EX), 32'd2);
        advance();
        bus.WriteReg_MEM = 0; bus.WriteReg_WB = 0; bus.rs_EX = 0; bus.rt_EX = 0;
        sample();
        check("fwd_r0", 32'(bus.FwdA_EX), 32'd0);
        advance();

        // multiply: 3 hold cycles after the start cycle
        clear_in();
        bus.MulStart_EX = 1;
        sample();
        advance();
        clear_in();
        for (int i = 0; i < MUL_LAT - 1; i++) begin
            sample();
            check("mul_hold_pcw", 32'(bus.PCWrite), 32'd0);
            check("mul_hold_emf", 32'(bus.EXMEM_Flush), 32'd1);
            advance();
        end
        sample();
        check("mul_done_pcw", 32'(bus.PCWrite), 32'd1);
        advance();

        // branch flush on second MUL cycle aborts the hold
        bus.MulStart_EX = 1;
        sample();
        advance();
        clear_in();
        sample();
        advance();
        bus.PCSrc_MEM = 1;
        sample();
        check("br_pcw", 32'(bus.PCWrite), 32'd1);
        check("br_iff", 32'(bus.IFID_Flush), 32'd1);
        advance();
        clear_in();
        sample();
        check("br_nohold", 32'(bus.PCWrite), 32'd1);
        advance();

        // jr with ALU producer, then with load producer
        bus.JR_ID = 1; bus.rs_ID = 31; bus.RegWrite_EX = 1; bus.WriteReg_EX = 31;
        sample();
        check("jr_stall", 32'(bus.PCWrite), 32'd0);
        advance();
        bus.RegWrite_EX = 0; bus.WriteReg_EX = 0; bus.RegWrite_MEM = 1; bus.WriteReg_MEM = 31;
        sample();
        check("jr_fwd_mem", 32'(bus.FwdJR_ID), 32'd1);
        advance();
        bus.RegWrite_EX = 1; bus.WriteReg_EX = 31; bus.MemRead_EX = 1;
        bus.RegWrite_MEM = 0; bus.WriteReg_MEM = 0;
        sample();
        advance();
        bus.RegWrite_EX = 0; bus.WriteReg_EX = 0; bus.MemRead_EX = 0;
        bus.RegWrite_MEM = 1; bus.WriteReg_MEM = 31; bus.MemRead_MEM = 1;
        sample();
        check("jr_ld_stall", 32'(bus.PCWrite), 32'd0);
        advance();
        bus.RegWrite_MEM = 0; bus.WriteReg_MEM = 0; bus.MemRead_MEM = 0;
        bus.RegWrite_WB = 1; bus.WriteReg_WB = 31;
        sample();
        check("jr_fwd_wb", 32'(bus.FwdJR_ID), 32'd2);
        advance();

        // asynchronous reset in the middle of a multiply
        clear_in();
        bus.MulStart_EX = 1;
        sample();
        advance();
        clear_in();
        #2;
        rst_n = 1'b0;
        hold_left = 0; m_stall = 0; m_flush = 0;
        #1;
        check_all();
        check("rst_mid_idw", 32'(bus.IDEX_Write), 32'd0);
        advance();
        rst_n = 1'b1;
        sample();
        check("rst_run", 32'(bus.dbg_state), 32'd0);
        advance();

        // random traffic over a small register set so dependencies are frequent
        for (int n = 0; n < 600; n++) begin
            bus.rs_ID = 5'($urandom_range(0, 3)); bus.rt_ID = 5'($urandom_range(0, 3));
            bus.UsesRt_ID = 1'($urandom_range(0, 1)); bus.JR_ID = ($urandom_range(0, 3) == 0);
            bus.rs_EX = 5'($urandom_range(0, 3)); bus.rt_EX = 5'($urandom_range(0, 3));
            bus.RegWrite_EX = 1'($urandom_range(0, 1)); bus.MemRead_EX = 1'($urandom_range(0, 1));
            bus.WriteReg_EX = 5'($urandom_range(0, 3)); bus.MulStart_EX = ($urandom_range(0, 7) == 0);
            bus.RegWrite_MEM = 1'($urandom_range(0, 1)); bus.MemRead_MEM = 1'($urandom_range(0, 1));
            bus.WriteReg_MEM = 5'($urandom_range(0, 3)); bus.RegWrite_WB = 1'($urandom_range(0, 1));
            bus.WriteReg_WB = 5'($urandom_range(0, 3)); bus.PCSrc_MEM = ($urandom_range(0, 9) == 0);
            sample();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Generates the EX-operand and ID-JR forwarding selects.
- Generates load-use and JR stalls, holds the pipeline while a multi-cycle multiply occupies EX, and flushes younger stages on a taken branch resolved in MEM.
- Replaces the free-running pipeline registers' implicit always-advance behaviour with explicit write/flush enables.

Parameters:
REG_AW, 5, register address width
MUL_LAT, 4, cycles a multiply occupies EX (>=1; 1 = single-cycle, no hold)
CNT_W, 32, width of optional statistics counters

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous reset, active-low
rs_ID  in  REG_AW  ID source register rs
rt_ID  in  REG_AW  ID source register rt
UsesRt_ID  in  1  ID instruction reads rt (R-type, store, branch)
JR_ID  in  1  ID instruction is jr (reads rs in ID)
rs_EX  in  REG_AW  EX source rs
rt_EX  in  REG_AW  EX source rt
MemRead_EX  in  1  EX instruction is a load
RegWrite_EX  in  1  EX instruction writes a register
WriteReg_EX  in  REG_AW  EX destination
MulStart_EX  in  1  multiply entered EX this cycle
MemRead_MEM  in  1  MEM instruction is a load
RegWrite_MEM  in  1  MEM writes a register
WriteReg_MEM  in  REG_AW  MEM destination
RegWrite_WB  in  1  WB writes a register
WriteReg_WB  in  REG_AW  WB destination
PCSrc_MEM  in  1  taken branch resolved in MEM
PCWrite  out  1  PC update enable
IFID_Write  out  1  IF/ID register enable
IFID_Flush  out  1  IF/ID clear to nop
IDEX_Write  out  1  ID/EX register enable
IDEX_Flush  out  1  ID/EX clear to nop
EXMEM_Flush  out  1  EX/MEM clear to nop
FwdA_EX  out  2  ALU A select: 00 regfile, 01 MEM/WB, 10 EX/MEM
FwdB_EX  out  2  ALU B select, same encoding
FwdJR_ID  out  2  jr target select: 00 regfile, 01 EX/MEM, 10 MEM/WB
StallCnt  out  CNT_W  stall cycles (optional feature)
FlushCnt  out  CNT_W  branch flush events (optional feature)

Behaviour:
- Reset (Rst=0, asynchronous):
  - State goes to RUN, the mul counter to 0, and the optional counters to 0.
  - While Rst=0, outputs are forced: PCWrite=0, IFID_Write=0, IDEX_Write=0, IFID_Flush=1, IDEX_Flush=1, EXMEM_Flush=1, all Fwd*=00.
- A "match" with a source register requires RegWrite=1, destination != 0, and equal address. Register 0 never forwards or stalls.
- Forwarding (combinational):
  - FwdA_EX=10 on an EX/MEM match with rs_EX.
  - Otherwise FwdA_EX=01 on a MEM/WB match.
  - Otherwise FwdA_EX=00. The MEM match wins over WB.
  - FwdB_EX follows the same rules with rt_EX.
- JR forwarding and stalls:
  - When JR_ID=1 and rs_ID matches MEM with MemRead_MEM=0: FwdJR_ID=01.
  - Otherwise, on a WB match: FwdJR_ID=10.
  - JR_ID=1 with an EX match, or a MEM match where MemRead_MEM=1, is a JR stall.
- Load-use: MemRead_EX=1 with WriteReg_EX matching rs_ID, or matching rt_ID when UsesRt_ID=1, is a load-use stall.
- Default outputs in RUN: all write enables 1, all flushes 0.
- States:
  - RUN, with a stall (load-use or JR): PCWrite=0, IFID_Write=0, IDEX_Flush=1 (one bubble). Stay in RUN; the condition is re-evaluated each cycle.
  - RUN, with MulStart_EX=1 and MUL_LAT>1: load counter=MUL_LAT-1 and go to MUL. The stall is also evaluated this cycle.
  - MUL: PCWrite=0, IFID_Write=0, IDEX_Write=0, EXMEM_Flush=1. Decrement the counter; go to RUN when it reaches 1. Total EX occupancy is exactly MUL_LAT cycles.
- Flush priority (highest):
  - PCSrc_MEM=1 in any state gives IFID_Flush=1, IDEX_Flush=1, EXMEM_Flush=1, PCWrite=1, IFID_Write=1, IDEX_Write=1.
  - Any stall in the same cycle is cancelled.
  - MUL aborts to RUN with counter=0.
- MulStart_EX while already in MUL is ignored.
- Latency: all control outputs are combinational on the current inputs and state; state updates on the rising Clk edge.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined:
  - StallCnt increments by 1 every cycle in which PCWrite=0 and Rst=1.
  - FlushCnt increments on each cycle with PCSrc_MEM=1.
  - Both saturate at 2^CNT_W-1 and clear only on reset.
- When undefined: StallCnt and FlushCnt are constant 0, and no counter flops are instantiated.

Test Plan:
- lw $t0 in EX (MemRead_EX=1, WriteReg_EX=8), rs_ID=8 -> exactly one cycle of PCWrite=0, IFID_Write=0, IDEX_Flush=1. Next cycle FwdA_EX=01.
- RegWrite_MEM=1, WriteReg_MEM=9 and RegWrite_WB=1, WriteReg_WB=9, rs_EX=9, rt_EX=9 -> FwdA_EX=10, FwdB_EX=10. Same case with WriteReg=0 -> 00.
- MulStart_EX=1 with MUL_LAT=4 -> PCWrite=0 and IDEX_Write=0 for exactly 3 cycles, with EXMEM_Flush=1 each of those cycles. RUN on the 4th cycle.
- PCSrc_MEM=1 on the second MUL cycle -> all three flushes=1, PCWrite=1, state RUN next cycle, no further hold.
- JR_ID=1, rs_ID=31, RegWrite_EX=1, WriteReg_EX=31 -> one stall cycle, then FwdJR_ID=01. With MemRead_MEM=1 -> second stall, then FwdJR_ID=10.
- Rst driven low mid-MUL -> outputs immediately forced to reset values. After release, state is RUN and StallCnt=0 (HAZARD_STATS_EN defined).
